// File: rtl/buffer2sram_scheduler.sv
// Descriptor queue and issue sequencer for the buffer2sram_input mover:
// validates, queues, and hands transfers over one at a time.
module buffer2sram_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_buf_start,
    input  logic [7:0]                    req_buf_end,
    input  logic [12:0]                   req_sram_start,
    input  logic                          flush,
    output logic [7:0]                    BUF_ADDR_start,
    output logic [7:0]                    BUF_ADDR_end,
    output logic [12:0]                   SRAM_ADDR_start,
    output logic                          buffer2sram_start,
    input  logic                          buffer2sram_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   queue_count,
    output logic [CNT_W-1:0]              done_count,
    output logic                          err_pulse,
    output logic [1:0]                    err_code
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0]  buf_start;
        logic [7:0]  buf_end;
        logic [12:0] sram_start;
    } desc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    desc_t             mem_q [FIFO_DEPTH];
    desc_t             cur_q, cur_d;
    desc_t             req_desc;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
    logic              err_pulse_q, err_pulse_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              accept;
    logic              push;
    logic              pop;
    logic [1:0]        chk_code;
    logic [6:0]        span;
    logic [7:0]        sram_end;

    assign req_desc = '{
        buf_start:  req_buf_start,
        buf_end:    req_buf_end,
        sram_start: req_sram_start
    };

    assign req_ready = (cnt_q < DEPTH_C);
    assign accept    = req_valid && req_ready;

    // Span only matters once the range is known to be ordered.
    assign span     = req_buf_end[6:0] - req_buf_start[6:0];
    assign sram_end = {1'b0, req_sram_start[6:0]} + {1'b0, span};

    always_comb begin
        chk_code = 2'b00;
        if (req_buf_start[7] != req_buf_end[7]) begin
            chk_code = 2'b01;
        end else if (req_buf_end[6:0] < req_buf_start[6:0]) begin
            chk_code = 2'b10;
        end else if (sram_end > 8'd127) begin
            chk_code = 2'b11;
        end
    end

    assign push = accept && (chk_code == 2'b00) && !flush;

    always_comb begin
        err_pulse_d = accept && (chk_code != 2'b00);
        err_code_d  = err_code_q;
        if (err_pulse_d) begin
            err_code_d = chk_code;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        done_cnt_d = done_cnt_q;
        case (state_q)
            IDLE: begin
                if ((cnt_q != '0) && !flush) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (buffer2sram_done) begin
                    done_cnt_d = done_cnt_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cur_d = cur_q;
        if (pop) begin
            cur_d = mem_q[rd_ptr_q];
        end
    end

    // Flush and pop are exclusive, as are flush and push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push && pop) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            done_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            done_cnt_q  <= done_cnt_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_desc;
        end
    end

    assign BUF_ADDR_start    = cur_q.buf_start;
    assign BUF_ADDR_end      = cur_q.buf_end;
    assign SRAM_ADDR_start   = cur_q.sram_start;
    assign buffer2sram_start = (state_q == ISSUE);
    assign busy              = (state_q != IDLE) || (cnt_q != '0);
    assign queue_count       = cnt_q;
    assign done_count        = done_cnt_q;
    assign err_pulse         = err_pulse_q;
    assign err_code          = err_code_q;

endmodule

// File: tb/tb_buffer2sram_scheduler.sv
// Bench for buffer2sram_scheduler: directed scenarios plus random traffic
// against a transaction-level queue model.
module tb_buffer2sram_scheduler;

    localparam int DEPTH = 4;
    localparam int CW    = 4;

    typedef struct packed {
        logic [7:0]  bs;
        logic [7:0]  be;
        logic [12:0] ss;
    } desc_t;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    desc_t         din;
    logic          flush;
    logic [7:0]    BUF_ADDR_start;
    logic [7:0]    BUF_ADDR_end;
    logic [12:0]   SRAM_ADDR_start;
    logic          buffer2sram_start;
    logic          buffer2sram_done;
    logic          busy;
    logic [2:0]    queue_count;
    logic [CW-1:0] done_count;
    logic          err_pulse;
    logic [1:0]    err_code;

    buffer2sram_scheduler #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_buf_start(din.bs),
        .req_buf_end(din.be),
        .req_sram_start(din.ss),
        .flush(flush),
        .BUF_ADDR_start(BUF_ADDR_start),
        .BUF_ADDR_end(BUF_ADDR_end),
        .SRAM_ADDR_start(SRAM_ADDR_start),
        .buffer2sram_start(buffer2sram_start),
        .buffer2sram_done(buffer2sram_done),
        .busy(busy),
        .queue_count(queue_count),
        .done_count(done_count),
        .err_pulse(err_pulse),
        .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    ncmp = 0;
    int    nerr = 0;

    desc_t q[$];
    desc_t cur;
    bit    inflight;
    int    pop_edge;
    int    edge_n;
    int    dcnt;
    bit    errp;
    int    errc;
    bit    m_acc;

    function automatic int classify(desc_t d);
        int lo_s = int'(d.bs[6:0]);
        int lo_e = int'(d.be[6:0]);
        int ss   = int'(d.ss[6:0]);
        if (d.bs[7] != d.be[7]) return 1;
        if (lo_e < lo_s) return 2;
        if (ss + (lo_e - lo_s) > 127) return 3;
        return 0;
    endfunction

    function automatic desc_t mk(int bs, int be, int ss);
        desc_t d;
        d.bs = 8'(bs);
        d.be = 8'(be);
        d.ss = 13'(ss);
        return d;
    endfunction

    function automatic desc_t rand_desc();
        desc_t d;
        int lo;
        int hi;
        d.bs = 8'($urandom);
        d.be = 8'($urandom);
        d.ss = 13'($urandom);
        if ($urandom_range(0, 9) < 7) begin
            lo = $urandom_range(0, 127);
            hi = $urandom_range(lo, 127);
            d.be[7]   = d.bs[7];
            d.bs[6:0] = 7'(lo);
            d.be[6:0] = 7'(hi);
            d.ss[6:0] = 7'($urandom_range(0, 127 - (hi - lo)));
        end
        return d;
    endfunction

    task automatic model_reset();
        q.delete();
        cur      = '0;
        inflight = 0;
        pop_edge = -10;
        dcnt     = 0;
        errp     = 0;
        errc     = 0;
        m_acc    = 0;
    endtask

    task automatic model_edge();
        int  c;
        bit  do_pop;
        bit  do_done;
        edge_n++;
        m_acc   = req_valid && (q.size() < DEPTH);
        c       = classify(din);
        do_pop  = !inflight && (q.size() > 0) && !flush;
        do_done = inflight && buffer2sram_done && (edge_n >= pop_edge + 2);
        errp    = m_acc && (c != 0);
        if (errp) errc = c;
        if (do_pop) begin
            cur      = q.pop_front();
            inflight = 1;
            pop_edge = edge_n;
        end
        if (do_done) begin
            inflight = 0;
            dcnt     = (dcnt + 1) % (1 << CW);
        end
        if (flush) q.delete();
        else if (m_acc && c == 0) q.push_back(din);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
        chk("queue_count", 32'(queue_count), 32'(q.size()));
        chk("busy", 32'(busy), 32'(inflight || q.size() > 0));
        chk("start", 32'(buffer2sram_start),
            32'(inflight && edge_n == pop_edge));
        chk("buf_start", 32'(BUF_ADDR_start), 32'(cur.bs));
        chk("buf_end", 32'(BUF_ADDR_end), 32'(cur.be));
        chk("sram_start", 32'(SRAM_ADDR_start), 32'(cur.ss));
        chk("done_count", 32'(done_count), 32'(dcnt));
        chk("err_pulse", 32'(err_pulse), 32'(errp));
        chk("err_code", 32'(err_code), 32'(errc));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic offer(input desc_t d, input int bound);
        bit got = 0;
        req_valid = 1'b1;
        din       = d;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            got = m_acc;
        end
        req_valid = 1'b0;
        ncmp++;
        assert (got) else begin
            nerr++;
            $error("FAIL offer_timeout: observed %0d expected 1", got);
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            buffer2sram_done = ($urandom_range(0, 2) == 0);
            step();
            if (!inflight && q.size() == 0) break;
        end
        buffer2sram_done = 1'b0;
        step();
        chk("drained_busy", 32'(busy), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        din = '0;
        flush = 1'b0;
        buffer2sram_done = 1'b0;
        edge_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_ready", 32'(req_ready), 32'(1));
        rst = 1'b0;

        // single transfer
        offer(mk(8'h05, 8'h0A, 13'h0083), 2);
        step();
        chk("t1_start", 32'(buffer2sram_start), 32'(1));
        chk("t1_bs", 32'(BUF_ADDR_start), 32'h05);
        chk("t1_be", 32'(BUF_ADDR_end), 32'h0A);
        chk("t1_ss", 32'(SRAM_ADDR_start), 32'h0083);
        repeat (3) step();
        chk("t1_hold", 32'(BUF_ADDR_end), 32'h0A);
        buffer2sram_done = 1'b1;
        step();
        buffer2sram_done = 1'b0;
        chk("t1_done", 32'(done_count), 32'(1));
        chk("t1_busy", 32'(busy), 32'(0));

        // back-to-back
        offer(mk(8'h81, 8'h90, 13'h0100), 2);
        offer(mk(8'h00, 8'h7F, 13'h0000), 2);
        offer(mk(8'h20, 8'h20, 13'h1F7F), 2);
        drain(200);
        chk("b2b_done", 32'(done_count), 32'(4));

        // backpressure with a stalled mover
        for (int i = 0; i < 5; i++) offer(mk(i, i + 3, 13'h0040 + i), 2);
        req_valid = 1'b1;
        din = mk(8'h10, 8'h11, 13'h0002);
        repeat (3) step();
        chk("bp_ready", 32'(req_ready), 32'(0));
        chk("bp_count", 32'(queue_count), 32'(4));
        buffer2sram_done = 1'b1;
        step();
        buffer2sram_done = 1'b0;
        offer(mk(8'h10, 8'h11, 13'h0002), 4);
        drain(300);

        // rejected descriptors
        offer(mk(8'h7E, 8'h81, 0), 2);
        chk("e1_pulse", 32'(err_pulse), 32'(1));
        chk("e1_code", 32'(err_code), 32'(1));
        offer(mk(8'h10, 8'h08, 0), 2);
        chk("e2_code", 32'(err_code), 32'(2));
        offer(mk(8'h00, 8'h10, 13'h0078), 2);
        chk("e3_code", 32'(err_code), 32'(3));
        chk("e3_queue", 32'(queue_count), 32'(0));
        step();
        chk("e3_pulse_low", 32'(err_pulse), 32'(0));
        chk("e3_code_hold", 32'(err_code), 32'(3));

        // reset while waiting on the mover
        offer(mk(8'h03, 8'h09, 13'h0200), 2);
        repeat (3) step();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_start", 32'(buffer2sram_start), 32'(0));
        chk("rst_addr", 32'(BUF_ADDR_start), 32'(0));
        @(posedge clk);
        #1;
        check_all();
        #2;
        rst = 1'b0;
        offer(mk(8'h84, 8'h88, 13'h0010), 2);
        step();
        chk("rst_reissue", 32'(buffer2sram_start), 32'(1));
        drain(200);

        // flush with one in flight and three queued
        do_reset();
        offer(mk(8'h01, 8'h02, 13'h0001), 2);
        offer(mk(8'h03, 8'h04, 13'h0002), 2);
        offer(mk(8'h05, 8'h06, 13'h0003), 2);
        offer(mk(8'h07, 8'h08, 13'h0004), 2);
        chk("fl_pre", 32'(queue_count), 32'(3));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_count", 32'(queue_count), 32'(0));
        chk("fl_busy", 32'(busy), 32'(1));
        buffer2sram_done = 1'b1;
        step();
        buffer2sram_done = 1'b0;
        repeat (5) step();
        chk("fl_done", 32'(done_count), 32'(1));
        chk("fl_idle", 32'(busy), 32'(0));

        // random traffic, including wrap of the completion counter
        for (int i = 0; i < 600; i++) begin
            req_valid        = ($urandom_range(0, 1) == 1);
            din              = rand_desc();
            flush            = ($urandom_range(0, 24) == 0);
            buffer2sram_done = ($urandom_range(0, 3) == 0);
            step();
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
